mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_pick.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the unified-memory port arbiter.
//   state_t - arbiter FSM states (IDLE / ISSUE / WAIT / RESP)
//   REQ_IF  - owner code for the instruction-fetch requester
//   REQ_D   - owner code for the data load/store requester
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the two requester handshakes and the memory
// port of the arbiter.
//   IF side : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   D side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory  : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status  : busy
// Modport slave is the arbiter's view; master is the surrounding
// core/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner selection for the memory port arbiter.
// Ports:
//   if_req, d_req - live request lines
//   starve_cnt    - consecutive IF losses (fixed-priority mode)
//   last_grant    - owner of the previous grant (round-robin mode)
//   winner        - REQ_IF or REQ_D
//   valid         - at least one request present
// Build option MEM_ARB_RR_EN: defined -> round-robin between the two
// requesters; undefined -> D has priority, IF is forced through once it
// has lost STARVE_MAX arbitrations in a row.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    input  logic             last_grant,
    output logic             winner,
    output logic             valid
);
    import mem_arb_pkg::*;

    assign valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    // Starvation counter has no role when the grant alternates.
    logic unused_starve;
    assign unused_starve = ^starve_cnt;

    always_comb begin
        winner = REQ_D;
        if (if_req && d_req) begin
            winner = ~last_grant;   // whoever did not win last time
        end else if (if_req) begin
            winner = REQ_IF;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_grant;

    always_comb begin
        winner = REQ_D;
        if (if_req && (!d_req || (starve_cnt >= CNT_W'(STARVE_MAX)))) begin
            winner = REQ_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and data load/store (D). One access at a time; all memory-port and
// requester outputs are registered.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (requester handshakes, memory port, busy)
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed priority
// with starvation guard (see mem_arb_pick).
// Sequence per access: IDLE (arbitrate) -> ISSUE (gnt + mem_en) ->
// [read only] WAIT x MEM_LAT -> RESP (rvalid) -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    import mem_arb_pkg::*;

    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W = $clog2(MEM_LAT + 1);

    state_t              state_reg;
    logic                owner_reg;
    logic                last_grant_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [CNT_W-1:0]    starve_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;

    logic                if_gnt_reg;
    logic                d_gnt_reg;
    logic                if_rvalid_reg;
    logic                d_rvalid_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic                busy_reg;

    logic                pick_winner;
    logic                pick_valid;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_cnt_reg),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= REQ_IF;
            last_grant_reg <= REQ_IF;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            starve_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            if_gnt_reg     <= 1'b0;
            d_gnt_reg      <= 1'b0;
            if_rvalid_reg  <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            // Single-cycle pulses default low; the state that needs them
            // raises them for exactly one cycle.
            if_gnt_reg    <= 1'b0;
            d_gnt_reg     <= 1'b0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A lone D request, or IF idle, means IF is not being
                    // starved right now.
                    if (!bus.if_req) begin
                        starve_cnt_reg <= '0;
                    end else if (pick_valid) begin
                        if (pick_winner == REQ_IF) begin
                            starve_cnt_reg <= '0;
                        end else if (starve_cnt_reg < CNT_W'(STARVE_MAX)) begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
                    end

                    if (pick_valid) begin
                        owner_reg      <= pick_winner;
                        last_grant_reg <= pick_winner;
                        mem_en_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ISSUE;
                        if (pick_winner == REQ_D) begin
                            we_reg     <= bus.d_we;
                            addr_reg   <= bus.d_addr;
                            wdata_reg  <= bus.d_wdata;
                            mem_we_reg <= bus.d_we;
                            d_gnt_reg  <= 1'b1;
                        end else begin
                            we_reg     <= 1'b0;     // fetch is read-only
                            addr_reg   <= bus.if_addr;
                            wdata_reg  <= '0;
                            if_gnt_reg <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (we_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= WAIT_W'(MEM_LAT);
                    end
                end

                WAIT: begin
                    if (wait_cnt_reg == WAIT_W'(1)) begin
                        // Last wait cycle: read data is valid on the port.
                        if (owner_reg == REQ_IF) begin
                            if_rdata_reg  <= bus.mem_rdata;
                            if_rvalid_reg <= 1'b1;
                        end else begin
                            d_rdata_reg   <= bus.mem_rdata;
                            d_rvalid_reg  <= 1'b1;
                        end
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_reg;
    assign bus.d_gnt     = d_gnt_reg;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.d_rvalid  = d_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    // Address/write data are the latched request registers themselves.
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.busy      = busy_reg;

endmodule
